// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state and grant types for the data-RAM arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DONE} arb_state_t;
  typedef enum logic {GNT_CORE, GNT_DMA} gnt_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, DMA and RAM-side signals of the data-RAM arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int SIZE = 32
);
  logic c_req, c_we, c_stall;
  logic [ADDR_W-1:0] c_addr;
  logic [SIZE-1:0] c_wdata, c_rdata;
  logic d_start, d_we, d_beat, d_busy, d_done;
  logic [ADDR_W-1:0] d_base;
  logic [ADDR_W:0] d_len;
  logic [SIZE-1:0] d_wdata, d_rdata;
  logic ram_memwrite;
  logic [ADDR_W-1:0] ram_address;
  logic [SIZE-1:0] ram_write_data, ram_read_data;
  modport slave (
    input c_req, c_we, c_addr, c_wdata, d_start, d_we, d_base, d_len, d_wdata, ram_read_data,
    output c_rdata, c_stall, d_rdata, d_beat, d_busy, d_done, ram_memwrite, ram_address, ram_write_data
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, d_start, d_we, d_base, d_len, d_wdata, ram_read_data,
    input c_rdata, c_stall, d_rdata, d_beat, d_busy, d_done, ram_memwrite, ram_address, ram_write_data
  );
endinterface

// File: rtl/dmem_burst_agen.sv
// dmem_burst_agen: burst address and remaining-beat counters with wrap at MEM_DEPTH
module dmem_burst_agen #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr_q,
  output logic              last
);
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W:0] rem_q, rem_d;
  // explicit wrap keeps non-power-of-two depths inside the RAM
  always_comb begin
    addr_d = load ? base : step ? (addr_q == ADDR_W'(MEM_DEPTH - 1) ? '0 : addr_q + 1'b1) : addr_q;
    rem_d = load ? len : step ? rem_q - 1'b1 : rem_q;
  end
  assign last = rem_q == {{ADDR_W{1'b0}}, 1'b1};
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      rem_q <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between core accesses and DMA bursts
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int MEM_DEPTH = 1024,
  parameter int SIZE = 32,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic reset,
  dmem_arbiter_if.slave bus
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int WAIT_W = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  arb_state_t state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic we_q, we_d, load, beat, last;
  gnt_t gnt;
  logic [ADDR_W-1:0] dma_addr;
  logic [SIZE-1:0] wdata;
  // a pending beat yields to the core until the core has had MAX_WAIT grants in a row
  always_comb begin
    load = state_q == IDLE && bus.d_start;
    beat = !reset && state_q == BURST && (!bus.c_req || wait_cnt_q == WAIT_W'(MAX_WAIT));
    gnt = beat ? GNT_DMA : GNT_CORE;
    we_d = load ? bus.d_we : we_q;
    wait_cnt_d = (state_q == BURST && bus.c_req && !beat) ? wait_cnt_q + 1'b1 : '0;
    state_d = state_q == IDLE ? (load ? (bus.d_len != '0 ? BURST : DONE) : IDLE)
            : state_q == BURST ? (beat && last ? DONE : BURST) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_cnt_q <= '0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we_q <= we_d;
    end
  end
  dmem_burst_agen #(.MEM_DEPTH(MEM_DEPTH)) u_agen (
    .clk(clk), .reset(reset), .load(load), .step(beat),
    .base(bus.d_base), .len(bus.d_len), .addr_q(dma_addr), .last(last)
  );
  assign wdata = gnt == GNT_DMA ? bus.d_wdata : bus.c_wdata;
  assign bus.ram_write_data = wdata;
  assign bus.ram_address = gnt == GNT_DMA ? dma_addr : bus.c_addr;
  assign bus.ram_memwrite = !reset && (gnt == GNT_DMA ? we_q : bus.c_req && bus.c_we);
  assign bus.c_stall = bus.c_req && beat;
  assign bus.c_rdata = bus.ram_read_data;
  assign bus.d_rdata = bus.ram_read_data;
  assign bus.d_beat = beat;
  assign bus.d_busy = !reset && state_q != IDLE;
  assign bus.d_done = !reset && state_q == DONE;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven directed checks of the arbiter against a negedge-write RAM model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dmem_arbiter_if #(.ADDR_W(10), .SIZE(32)) bus ();
  dmem_arbiter #(.MEM_DEPTH(1024), .SIZE(32), .MAX_WAIT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] mem [1024] = '{default: '0};
  assign bus.ram_read_data = mem[bus.ram_address];
  always @(negedge clk) if (bus.ram_memwrite) mem[bus.ram_address] <= bus.ram_write_data;
  typedef struct {
    logic c_req, c_we;
    logic [9:0] c_addr;
    logic [31:0] c_wdata;
    logic d_start, d_we;
    logic [9:0] d_base;
    logic [10:0] d_len;
    logic [31:0] d_wdata;
    logic [4:0] x_flags;
    logic [9:0] x_addr;
    logic x_rd_en;
    logic [31:0] x_rd;
  } vec_t;
  vec_t vq[$];
  int n_chk = 0;
  int n_fail = 0;
  int idx = 0;
  function automatic vec_t mk(int cr, int cw, int ca, int cd, int ds, int dw, int db, int dl, int dd,
                              int xf, int xa, int xr, int xd);
    vec_t v;
    v.c_req = cr[0]; v.c_we = cw[0]; v.c_addr = 10'(ca); v.c_wdata = 32'(cd);
    v.d_start = ds[0]; v.d_we = dw[0]; v.d_base = 10'(db); v.d_len = 11'(dl); v.d_wdata = 32'(dd);
    v.x_flags = 5'(xf); v.x_addr = 10'(xa); v.x_rd_en = xr[0]; v.x_rd = 32'(xd);
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // flags = {c_stall, d_beat, d_busy, d_done, ram_memwrite}
  task automatic run(input vec_t v, input logic r);
    @(posedge clk);
    #1;
    reset = r;
    bus.c_req = v.c_req; bus.c_we = v.c_we; bus.c_addr = v.c_addr; bus.c_wdata = v.c_wdata;
    bus.d_start = v.d_start; bus.d_we = v.d_we; bus.d_base = v.d_base; bus.d_len = v.d_len;
    bus.d_wdata = v.d_wdata;
    #1;
    chk($sformatf("flags[%0d]", idx), 32'({bus.c_stall, bus.d_beat, bus.d_busy, bus.d_done, bus.ram_memwrite}),
        32'(v.x_flags));
    chk($sformatf("addr[%0d]", idx), 32'(bus.ram_address), 32'(v.x_addr));
    if (v.x_rd_en) chk($sformatf("rdata[%0d]", idx), v.x_flags[3] ? bus.d_rdata : bus.c_rdata, v.x_rd);
    idx++;
  endtask
  initial begin
    vec_t z;
    int ma[19] = '{10, 11, 12, 13, 1022, 1023, 0, 1, 5, 20, 50, 100, 101, 200, 400, 2, 300, 301, 302};
    int md[19] = '{'hA0, 'hA1, 'hA2, 'hA3, 'hB0, 'hB1, 'hB2, 'hB3, 'hDEADBEEF, 'h12345678, 0, 'hE0, 'hE1,
                   0, 0, 0, 'hF0, 'hF1, 0};
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00000, 0, 0, 0);
    run(z, 1'b1);
    run(z, 1'b1);
    run(z, 1'b0);
    vq.push_back(mk(1, 1, 5, 'hDEADBEEF, 0, 0, 0, 0, 0, 'b00001, 5, 0, 0));
    vq.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 'b00000, 5, 1, 'hDEADBEEF));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 10, 4, 0, 'b00000, 0, 0, 0));
    for (int i = 0; i < 4; i++) vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'hA0 + i, 'b01101, 10 + i, 0, 0));
    vq.push_back(mk(1, 0, 12, 0, 0, 0, 0, 0, 0, 'b00110, 12, 1, 'hA2));
    vq.push_back(mk(1, 0, 10, 0, 0, 0, 0, 0, 0, 'b00000, 10, 1, 'hA0));
    vq.push_back(mk(1, 0, 5, 0, 1, 0, 11, 3, 0, 'b00000, 5, 1, 'hDEADBEEF));
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++)
        if (b == 1 && k == 0) vq.push_back(mk(1, 1, 20, 'h12345678, 0, 0, 0, 0, 0, 'b00101, 20, 0, 0));
        else vq.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 'b00100, 5, 1, 'hDEADBEEF));
      vq.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 'b11100, 11 + b, 1, 'hA1 + b));
    end
    vq.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 'b00110, 5, 1, 'hDEADBEEF));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 1022, 4, 0, 'b00000, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'hB0 + i, 'b01101, (1022 + i) % 1024, 0, 0));
    vq.push_back(mk(1, 0, 1023, 0, 1, 1, 400, 2, 0, 'b00110, 1023, 1, 'hB1));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 'b00000, 0, 1, 'hB2));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 50, 0, 'hCC, 'b00000, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'b00110, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 100, 2, 0, 'b00000, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 200, 5, 'hE0, 'b01101, 100, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 200, 5, 'hE1, 'b01101, 101, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 200, 5, 0, 'b00110, 0, 0, 0));
    vq.push_back(mk(1, 0, 101, 0, 0, 0, 0, 0, 0, 'b00000, 101, 1, 'hE1));
    vq.push_back(mk(1, 0, 20, 0, 0, 0, 0, 0, 0, 'b00000, 20, 1, 'h12345678));
    foreach (vq[i]) run(vq[i], 1'b0);
    // reset lands on the third beat of a six-beat write burst
    run(mk(0, 0, 0, 0, 1, 1, 300, 6, 0, 'b00000, 0, 0, 0), 1'b0);
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 'hF0, 'b01101, 300, 0, 0), 1'b0);
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 'hF1, 'b01101, 301, 0, 0), 1'b0);
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 'hF2, 'b00000, 0, 0, 0), 1'b1);
    for (int i = 0; i < 4; i++) run(z, 1'b0);
    foreach (ma[i]) chk($sformatf("mem[%0d]", ma[i]), mem[ma[i]], 32'(md[i]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
